ram_march_bist: RTL and testbench
=================================

RAM_MARCH_BIST -- requirements
Module: ram_march_bist

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, RAM address width (depth 2^ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 8, RAM word width.
REQ-003 SHALL have parameter RD_LAT, default 2, cycles from read address presented to ram_q valid; legal range 1..7.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  run request pulse/level.
REQ-007 SHALL have port busy  output  1  test in progress.
REQ-008 SHALL have port done  output  1  test finished; sticky until next accepted start.
REQ-009 SHALL have port fail  output  1  at least one read mismatch; sticky until next accepted start.
REQ-010 SHALL have port fail_addr  output  ADDR_W  address of first mismatch.
REQ-011 SHALL have port fail_data  output  DATA_W  ram_q value at first mismatch.
REQ-012 SHALL have port ram_addr  output  ADDR_W  RAM port address, registered.
REQ-013 SHALL have port ram_wdata  output  DATA_W  RAM port write data, registered.
REQ-014 SHALL have port ram_we  output  1  RAM port write enable, registered.
REQ-015 SHALL have port ram_q  input  DATA_W  RAM port read data.

Function
REQ-016 SHALL act as initiator on one RAM port, running March sequence: M0 ascending w(0x00); M1 ascending r(0x00),w(0xFF); M2 descending r(0xFF),w(0x00); M3 descending r(0x00). "0xFF" means all-ones of DATA_W.
REQ-017 SHALL use states IDLE, WR0, RD, WAIT, CMP, WR, DONE; WR0 = M0 write, one address per cycle.
REQ-018 Per read: RD drives ram_addr, ram_we=0 for one cycle; WAIT holds ram_we=0 for RD_LAT-1 cycles; CMP samples ram_q RD_LAT cycles after RD, ram_we=0.
REQ-019 M1/M2: CMP -> WR (one cycle, ram_we=1, same address) -> next address RD; M3: CMP -> next address RD.
REQ-020 ram_we SHALL be 1 only in WR0 and WR; ram_wdata don't-care when ram_we=0.
REQ-021 Element transitions: after last address of an element, next cycle starts the next element at its first address (ascending 0, descending 2^ADDR_W-1); after M3 last CMP -> DONE.
REQ-022 Run length: busy high exactly 2^ADDR_W*(1+2*(RD_LAT+2)+(RD_LAT+1)) cycles (768 for defaults).
REQ-023 start sampled only in IDLE or DONE; accepted start clears done, fail, fail_addr, fail_data and sets busy next cycle; start while busy SHALL be ignored.
REQ-024 DONE: busy=0, done=1, ram_we=0; done rises on the same edge busy falls.
REQ-025 On mismatch in CMP: fail=1; fail_addr/fail_data captured only if fail was 0 (first mismatch kept).

Reset
REQ-026 rst_n low SHALL immediately force IDLE, busy=0, done=0, fail=0, fail_addr=0, fail_data=0, ram_addr=0, ram_wdata=0, ram_we=0, including mid-run.
REQ-027 After rst_n release, block SHALL stay IDLE until start.

Configuration
REQ-028 Macro BIST_STOP_ON_FAIL_EN defined: first mismatch in CMP SHALL transition to DONE next cycle (remaining operations skipped, no write for that address).
REQ-029 Macro undefined: mismatches SHALL only set flags; full sequence always runs to REQ-022 length.

Verification
REQ-030 Fault-free 64x8 RAM model, defaults, start pulse -> busy high 768 cycles, then done=1, fail=0.
REQ-031 Bit 3 of address 0x2A stuck-at-1, macro undefined -> busy 768 cycles, fail=1, fail_addr=0x2A, fail_data=0x08.
REQ-032 Same fault, BIST_STOP_ON_FAIL_EN defined -> busy high 235 cycles, done=1, fail=1, fail_addr=0x2A, no further ram_we after failing CMP.
REQ-033 rst_n low at cycle 300 of run -> ram_we=0 and busy=0 asynchronously; new start -> full 768-cycle pass.
REQ-034 start held high throughout run -> ignored while busy; re-accepted in DONE, flags cleared, second run 768 cycles.
REQ-035 RD_LAT=3 with 3-cycle-latency RAM model -> busy 960 cycles, fail=0.

Source files
------------

// File: rtl/ram_march_bist.sv
// March C- style memory BIST driving one synchronous RAM port with configurable read latency.
// Optional macro BIST_STOP_ON_FAIL_EN: end the run at the first read mismatch.
module ram_march_bist #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [2:0] {IDLE, WR0, RD, WAIT, CMP, WR, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [DATA_W-1:0] ONES      = '1;
  localparam logic [2:0]        WAIT_INIT = 3'(RD_LAT > 1 ? RD_LAT - 2 : 0);
`ifdef BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [1:0]        r_elem, w_elem_next;   // 0: M0, 1: M1, 2: M2, 3: M3
  logic [2:0]        r_wait, w_wait_next;
  logic              w_accept, w_mismatch;
  logic [DATA_W-1:0] w_exp;
  logic              r_busy, r_done, r_fail, r_we;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [DATA_W-1:0] r_fail_data, r_wdata;

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_elem_next  = r_elem;
    w_wait_next  = r_wait;
    w_accept     = 1'b0;
    w_mismatch   = 1'b0;
    w_exp        = (r_elem == 2'd2) ? ONES : '0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = WR0;
          w_addr_next  = '0;
          w_elem_next  = 2'd0;
        end
      end
      WR0: begin
        if (r_addr == ADDR_MAX) begin
          w_state_next = RD;
          w_addr_next  = '0;
          w_elem_next  = 2'd1;
        end else begin
          w_addr_next = r_addr + 1'b1;
        end
      end
      RD: begin
        if (RD_LAT == 1) begin
          w_state_next = CMP;
        end else begin
          w_state_next = WAIT;
          w_wait_next  = WAIT_INIT;
        end
      end
      WAIT: begin
        if (r_wait == 3'd0) w_state_next = CMP;
        else                w_wait_next  = r_wait - 3'd1;
      end
      CMP: begin
        w_mismatch = (ram_q != w_exp);
        if (STOP_ON_FAIL && w_mismatch) begin
          w_state_next = DONE;
        end else if (r_elem != 2'd3) begin
          w_state_next = WR;
        end else if (r_addr == '0) begin
          w_state_next = DONE;
        end else begin
          w_state_next = RD;
          w_addr_next  = r_addr - 1'b1;
        end
      end
      WR: begin
        w_state_next = RD;
        // M1 walks up then hands over to M2 at the top; M2 walks down then hands over to M3 at the top.
        if (r_elem == 2'd1) begin
          if (r_addr == ADDR_MAX) w_elem_next = 2'd2;
          else                    w_addr_next = r_addr + 1'b1;
        end else begin
          if (r_addr == '0) begin
            w_elem_next = 2'd3;
            w_addr_next = ADDR_MAX;
          end else begin
            w_addr_next = r_addr - 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_elem      <= 2'd0;
      r_wait      <= 3'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_elem  <= w_elem_next;
      r_wait  <= w_wait_next;
      // Outputs are registered from the next state so they line up with the state they belong to.
      r_busy  <= (w_state_next != IDLE) && (w_state_next != DONE);
      r_done  <= (w_state_next == DONE);
      r_we    <= (w_state_next == WR0) || (w_state_next == WR);
      r_wdata <= (w_state_next == WR && w_elem_next == 2'd1) ? ONES : '0;
      if (w_accept) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_data <= '0;
      end else if (r_state == CMP && w_mismatch) begin
        r_fail <= 1'b1;
        if (!r_fail) begin
          r_fail_addr <= r_addr;
          r_fail_data <= ram_q;
        end
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign ram_we    = r_we;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: two instances (read latency 2 and 3) on behavioural RAMs with an
// injectable stuck-at bit, checked against an element-by-element model of the march algorithm.
module tb_ram_march_bist;

`ifdef BIST_STOP_ON_FAIL_EN
  localparam bit STOP_MODE = 1'b1;
`else
  localparam bit STOP_MODE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       busy_a, done_a, fail_a, we_a;
  logic       busy_b, done_b, fail_b, we_b;
  logic [5:0] faddr_a, addr_a, faddr_b, addr_b;
  logic [7:0] fdata_a, wdata_a, q_a, fdata_b, wdata_b, q_b;

  int  n_checks = 0;
  int  n_fail = 0;
  bit  f_en = 1'b0;
  int  f_addr = 0;
  int  f_bit = 0;
  bit  f_val = 1'b0;

  always #5 clk = ~clk;

  ram_march_bist #(.ADDR_W(6), .DATA_W(8), .RD_LAT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a), .fail(fail_a),
    .fail_addr(faddr_a), .fail_data(fdata_a), .ram_addr(addr_a), .ram_wdata(wdata_a),
    .ram_we(we_a), .ram_q(q_a));

  ram_march_bist #(.ADDR_W(6), .DATA_W(8), .RD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .fail(fail_b),
    .fail_addr(faddr_b), .fail_data(fdata_b), .ram_addr(addr_b), .ram_wdata(wdata_b),
    .ram_we(we_b), .ram_q(q_b));

  // Stuck-at fault acts on the read path of the addressed word.
  function automatic logic [7:0] fault_rd(input logic [5:0] a, input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (f_en && int'(a) == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  logic [7:0] mem_a [0:63];
  logic [7:0] pipe_a [0:1];
  logic [7:0] mem_b [0:63];
  logic [7:0] pipe_b [0:2];

  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= wdata_a;
    pipe_a[0] <= fault_rd(addr_a, mem_a[addr_a]);
    pipe_a[1] <= pipe_a[0];
    if (we_b) mem_b[addr_b] <= wdata_b;
    pipe_b[0] <= fault_rd(addr_b, mem_b[addr_b]);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign q_a = pipe_a[1];
  assign q_b = pipe_b[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Walks the three read elements over a fault-free array; the observed word is the written
  // pattern seen through the fault. Cycle cost: write 1, read L+1 (address, wait, compare).
  task automatic ref_march(input int lat, output bit rf, output int rfa, output int rfd,
                           output int full, output int stopc);
    int cyc;
    rf = 1'b0; rfa = 0; rfd = 0; stopc = 0;
    cyc = 64;
    for (int e = 1; e <= 3; e++) begin
      for (int k = 0; k < 64; k++) begin
        int a;
        logic [7:0] ex, obs;
        a  = (e == 1) ? k : 63 - k;
        ex = (e == 2) ? 8'hFF : 8'h00;
        obs = ex;
        if (f_en && a == f_addr) obs[f_bit] = f_val;
        cyc += lat + 1;
        if (obs != ex && !rf) begin
          rf = 1'b1; rfa = a; rfd = int'(obs); stopc = cyc;
        end
        if (e != 3) cyc += 1;
      end
    end
    full = cyc;
  endtask

  // Counts busy cycles from the current negedge until busy drops (bounded).
  task automatic count_busy(input bit use_b, output int cyc, output bit bad_we);
    int guard;
    cyc = 0; bad_we = 1'b0; guard = 0;
    while (guard < 5000) begin
      if (!(use_b ? busy_b : busy_a)) break;
      cyc++;
      if ((use_b ? fail_b : fail_a) && (use_b ? we_b : we_a)) bad_we = 1'b1;
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) check("busy_timeout", 64'(guard), 64'(0));
  endtask

  task automatic do_run(input bit use_b, output int cyc, output bit bad_we);
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    count_busy(use_b, cyc, bad_we);
  endtask

  task automatic run_and_check(input string tag, input bit use_b, input int exp_cyc,
                               input bit e_fail, input int e_fa, input int e_fd);
    int cyc;
    bit bad_we;
    do_run(use_b, cyc, bad_we);
    $display("run %s dut=%s fault=%0d addr=%0d bit=%0d val=%0d cycles=%0d fail=%0d fail_addr=%0d fail_data=%0d",
             tag, use_b ? "lat3" : "lat2", f_en, f_addr, f_bit, f_val, cyc,
             use_b ? fail_b : fail_a, use_b ? faddr_b : faddr_a, use_b ? fdata_b : fdata_a);
    check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_done"}, 64'(use_b ? done_b : done_a), 64'(1));
    check({tag, "_fail"}, 64'(use_b ? fail_b : fail_a), 64'(e_fail));
    check({tag, "_fail_addr"}, 64'(use_b ? faddr_b : faddr_a), 64'(e_fa));
    check({tag, "_fail_data"}, 64'(use_b ? fdata_b : fdata_a), 64'(e_fd));
`ifdef BIST_STOP_ON_FAIL_EN
    check({tag, "_we_after_fail"}, 64'(bad_we), 64'(0));
`endif
  endtask

  typedef struct {
    bit use_b;
    bit fe;
    int fa;
    int fb;
    bit fv;
    int cyc_full;
    int cyc_stop;
    bit e_fail;
    int e_fa;
    int e_fd;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl [5];
    int cyc1, cyc2;
    bit bad1;

    tbl[0] = '{1'b0, 1'b0, 0,    0, 1'b0, 768, 768, 1'b0, 0,    0};
    tbl[1] = '{1'b0, 1'b1, 'h2A, 3, 1'b1, 768, 235, 1'b1, 'h2A, 'h08};
    tbl[2] = '{1'b0, 1'b1, 'h00, 0, 1'b0, 768, 575, 1'b1, 'h00, 'hFE};
    tbl[3] = '{1'b1, 1'b0, 0,    0, 1'b0, 960, 960, 1'b0, 0,    0};
    tbl[4] = '{1'b1, 1'b1, 'h3F, 7, 1'b1, 960, 383, 1'b1, 'h3F, 'h80};

    #12;
    check("rst_busy", 64'(busy_a), 64'(0));
    check("rst_done", 64'(done_a), 64'(0));
    check("rst_fail", 64'(fail_a), 64'(0));
    check("rst_ram_addr", 64'(addr_a), 64'(0));
    check("rst_ram_we", 64'(we_a), 64'(0));
    check("rst_ram_wdata", 64'(wdata_a), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_release", 64'({busy_a, done_a, busy_b, done_b}), 64'(0));

    for (int i = 0; i < 5; i++) begin
      f_en = tbl[i].fe; f_addr = tbl[i].fa; f_bit = tbl[i].fb; f_val = tbl[i].fv;
      run_and_check($sformatf("vec%0d", i), tbl[i].use_b,
                    (STOP_MODE && tbl[i].e_fail) ? tbl[i].cyc_stop : tbl[i].cyc_full,
                    tbl[i].e_fail, tbl[i].e_fa, tbl[i].e_fd);
    end

    for (int i = 0; i < 8; i++) begin
      bit rf;
      int rfa, rfd, full, stopc;
      f_en = 1'b1;
      f_addr = int'($urandom_range(0, 63));
      f_bit = int'($urandom_range(0, 7));
      f_val = 1'($urandom_range(0, 1));
      ref_march(i[0] ? 3 : 2, rf, rfa, rfd, full, stopc);
      run_and_check($sformatf("rnd%0d", i), i[0], (STOP_MODE && rf) ? stopc : full, rf, rfa, rfd);
    end

    // Asynchronous reset in the middle of a run, caught during a write cycle.
    f_en = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (299) @(negedge clk);
    for (int g = 0; g < 8 && !we_a; g++) @(negedge clk);
    check("midrun_we_before_reset", 64'(we_a), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    $display("run midrun_reset busy=%0d we=%0d", busy_a, we_a);
    check("midrun_reset_busy", 64'(busy_a), 64'(0));
    check("midrun_reset_we", 64'(we_a), 64'(0));
    check("midrun_reset_addr", 64'(addr_a), 64'(0));
    check("midrun_reset_done", 64'(done_a), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_idle", 64'({busy_a, done_a}), 64'(0));
    run_and_check("after_reset", 1'b0, 768, 1'b0, 0, 0);

    // Start held high: flags from a failing run are cleared, busy ignores start, rerun from DONE.
    f_en = 1'b1; f_addr = 'h2A; f_bit = 3; f_val = 1'b1;
    run_and_check("pre_hold", 1'b0, STOP_MODE ? 235 : 768, 1'b1, 'h2A, 'h08);
    f_en = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    check("hold_flags_cleared", 64'({fail_a, done_a, faddr_a, fdata_a}), 64'(0));
    count_busy(1'b0, cyc1, bad1);
    check("hold_run1_cycles", 64'(cyc1), 64'(768));
    check("hold_run1_done", 64'(done_a), 64'(1));
    @(negedge clk);
    check("hold_rerun_busy", 64'({busy_a, done_a}), 64'(2'b10));
    start_a = 1'b0;
    count_busy(1'b0, cyc2, bad1);
    $display("run start_held cycles1=%0d cycles2=%0d fail=%0d", cyc1, cyc2, fail_a);
    check("hold_run2_cycles", 64'(cyc2), 64'(768));
    check("hold_run2_done_fail", 64'({done_a, fail_a}), 64'(2'b10));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
